// File: rtl/game_sequencer.sv
// Breakout game sequencer: serve countdown, ball motion, wall/paddle/miss
// detection, lives and score. All outputs are registered.
module game_sequencer #(
    parameter int H_MIN       = 144,
    parameter int H_MAX       = 783,
    parameter int V_MIN       = 35,
    parameter int V_MAX       = 515,
    parameter int PADDLE_Y    = 500,
    parameter int PADDLE_HW   = 25,
    parameter int PADDLE_HH   = 5,
    parameter int BALL_H      = 3,
    parameter int STEP        = 2,
    parameter int START_LIVES = 3,
    parameter int SERVE_TICKS = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic [9:0]  paddle_x,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic [2:0]  state,
    output logic        paddle_en,
    output logic        game_over
);
    localparam int SERVE_Y = PADDLE_Y - PADDLE_HH - BALL_H - 1;
    localparam int PTOP    = PADDLE_Y - PADDLE_HH;
    localparam int CW      = $clog2(SERVE_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        MISS  = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t st;
    logic dx;
    logic dy;
    logic [CW-1:0] countdown;

    logic [10:0] bx_ext;
    logic [10:0] by_ext;
    logic signed [10:0] diff;
    logic [10:0] adiff;
    logic hit;
    logic miss;
    logic x_hi;
    logic x_lo;
    logic y_top;

    assign state  = st;
    assign bx_ext = {1'b0, ball_x};
    assign by_ext = {1'b0, ball_y};
    assign diff   = $signed(bx_ext) - $signed({1'b0, paddle_x});
    assign adiff  = diff[10] ? $unsigned(-diff) : $unsigned(diff);

    // Low-side wall tests are rearranged so nothing subtracts below zero.
    assign x_hi  = bx_ext + 11'(BALL_H + STEP) >= 11'(H_MAX);
    assign x_lo  = ball_x <= 10'(H_MIN + BALL_H + STEP);
    assign y_top = ball_y <= 10'(V_MIN + BALL_H + STEP);
    assign hit   = dy
                && (by_ext + 11'(BALL_H) < 11'(PTOP))
                && (by_ext + 11'(BALL_H + STEP) >= 11'(PTOP))
                && (adiff <= 11'(PADDLE_HW + BALL_H));
    assign miss  = dy && !hit
                && (by_ext + 11'(BALL_H + STEP) >= 11'(V_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            ball_x    <= 10'd464;
            ball_y    <= 10'(SERVE_Y);
            dx        <= 1'b1;
            dy        <= 1'b0;
            score     <= '0;
            lives     <= 2'(START_LIVES);
            countdown <= '0;
            paddle_en <= 1'b0;
            game_over <= 1'b0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (tick) begin
                        ball_x <= paddle_x;
                        ball_y <= 10'(SERVE_Y);
                    end
                    if (start) begin
                        st        <= SERVE;
                        countdown <= CW'(SERVE_TICKS);
                        score     <= '0;
                        lives     <= 2'(START_LIVES);
                        dx        <= 1'b1;
                        dy        <= 1'b0;
                        paddle_en <= 1'b1;
                    end
                end
                SERVE: begin
                    if (tick) begin
                        ball_x    <= paddle_x;
                        ball_y    <= 10'(SERVE_Y);
                        countdown <= countdown - CW'(1);
                        if (countdown == CW'(1))
                            st <= PLAY;
                    end
                end
                PLAY: begin
                    if (tick && miss) begin
                        st        <= MISS;
                        paddle_en <= 1'b0;
                    end else if (tick) begin
                        if (dx && x_hi) begin
                            ball_x <= 10'(H_MAX - BALL_H);
                            dx     <= 1'b0;
                        end else if (!dx && x_lo) begin
                            ball_x <= 10'(H_MIN + BALL_H);
                            dx     <= 1'b1;
                        end else if (dx) begin
                            ball_x <= ball_x + 10'(STEP);
                        end else begin
                            ball_x <= ball_x - 10'(STEP);
                        end
                        if (!dy && y_top) begin
                            ball_y <= 10'(V_MIN + BALL_H);
                            dy     <= 1'b1;
                        end else if (!dy) begin
                            ball_y <= ball_y - 10'(STEP);
                        end else if (hit) begin
                            ball_y <= 10'(PTOP - BALL_H - 1);
                            dy     <= 1'b0;
                            if (score != 16'hFFFF)
                                score <= score + 16'd1;
                        end else begin
                            ball_y <= ball_y + 10'(STEP);
                        end
                    end
                end
                MISS: begin
                    lives <= lives - 2'd1;
                    if (lives == 2'd1) begin
                        st        <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        st        <= SERVE;
                        countdown <= CW'(SERVE_TICKS);
                        ball_x    <= paddle_x;
                        ball_y    <= 10'(SERVE_Y);
                        dx        <= 1'b1;
                        dy        <= 1'b0;
                        paddle_en <= 1'b1;
                    end
                end
                OVER: begin
                    if (start) begin
                        st        <= IDLE;
                        lives     <= 2'(START_LIVES);
                        game_over <= 1'b0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a behavioural game model feeds a
// scoreboard queue that is checked one clk after each driven step.
module tb_game_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  paddle_x = 10'd450;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic [15:0] score;
    logic [1:0]  lives;
    logic [2:0]  state;
    logic        paddle_en;
    logic        game_over;

    game_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .paddle_x(paddle_x), .ball_x(ball_x), .ball_y(ball_y),
        .score(score), .lives(lives), .state(state),
        .paddle_en(paddle_en), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st, bx, by, dx, dy, score, lives, cd;
    } mdl_t;

    mdl_t m;
    logic [42:0] sb[$];
    int total = 0;
    int bad = 0;

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = 0; r.bx = 464; r.by = 491; r.dx = 1; r.dy = 0;
        r.score = 0; r.lives = 3; r.cd = 0;
        return r;
    endfunction

    function automatic logic [42:0] pack(mdl_t r);
        logic pen;
        logic gov;
        pen = (r.st == 1) || (r.st == 2);
        gov = (r.st == 4);
        return {3'(r.st), 10'(r.bx), 10'(r.by), 16'(r.score),
                2'(r.lives), pen, gov};
    endfunction

    function automatic mdl_t mnext(mdl_t c, bit t, bit s, int px);
        mdl_t n;
        int ad;
        bit h;
        n = c;
        case (c.st)
            0: begin
                if (t) begin n.bx = px; n.by = 491; end
                if (s) begin
                    n.st = 1; n.cd = 60; n.score = 0; n.lives = 3;
                    n.dx = 1; n.dy = 0;
                end
            end
            1: if (t) begin
                n.bx = px; n.by = 491; n.cd = c.cd - 1;
                if (c.cd == 1) n.st = 2;
            end
            2: if (t) begin
                ad = (c.bx > px) ? c.bx - px : px - c.bx;
                h = c.dy == 1 && c.by + 3 < 495 && c.by + 5 >= 495
                    && ad <= 28;
                if (c.dy == 1 && !h && c.by + 5 >= 515) begin
                    n.st = 3;
                end else begin
                    if (c.dx == 1 && c.bx + 5 >= 783) begin
                        n.bx = 780; n.dx = 0;
                    end else if (c.dx == 0 && c.bx - 5 <= 144) begin
                        n.bx = 147; n.dx = 1;
                    end else begin
                        n.bx = c.bx + (c.dx == 1 ? 2 : -2);
                    end
                    if (c.dy == 0) begin
                        if (c.by - 5 <= 35) begin n.by = 38; n.dy = 1; end
                        else n.by = c.by - 2;
                    end else if (h) begin
                        n.by = 491; n.dy = 0;
                        if (c.score < 65535) n.score = c.score + 1;
                    end else begin
                        n.by = c.by + 2;
                    end
                end
            end
            3: begin
                n.lives = c.lives - 1;
                if (c.lives == 1) n.st = 4;
                else begin
                    n.st = 1; n.cd = 60; n.bx = px; n.by = 491;
                    n.dx = 1; n.dy = 0;
                end
            end
            4: if (s) begin n.st = 0; n.lives = 3; end
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic [42:0] obs();
        return {state, ball_x, ball_y, score, lives, paddle_en, game_over};
    endfunction

    task automatic chk(input string tag, input logic [42:0] o,
                       input logic [42:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step(input bit t, input bit s, input int px);
        logic [42:0] e;
        tick = t;
        start = s;
        paddle_x = 10'(px);
        m = mnext(m, t, s, px);
        sb.push_back(pack(m));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("scoreboard", obs(), e);
    endtask

    function automatic int far_px(int bx);
        return (bx < 500) ? bx + 50 : bx - 50;
    endfunction

    int n;
    int px;

    initial begin
        m = mreset();
        #12;
        chk("reset_state", obs(), pack(mreset()));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        step(1, 0, 430);
        step(1, 0, 450);
        step(0, 1, 450);
        chk("serve_state", 43'(state), 43'(1));
        chk("serve_pen", 43'(paddle_en), 43'(1));
        for (int i = 0; i < 59; i++)
            step(1, (i % 9) == 0, 450);
        chk("serve_hold", 43'(state), 43'(1));
        step(1, 0, 450);
        chk("play_entry", 43'({state, ball_x, ball_y}),
            43'({3'd2, 10'd450, 10'd491}));
        step(1, 0, 450);
        chk("first_move", 43'({ball_x, ball_y}), 43'({10'd452, 10'd489}));

        n = 0;
        while (m.score < 1 && n < 2000) begin
            step(1, (n % 7) == 0, m.bx);
            n++;
        end
        chk("hit_timeout", 43'(n < 2000), 43'(1));
        chk("hit_score", 43'({score, ball_y}), 43'({16'd1, 10'd491}));

        n = 0;
        while (m.st != 3 && n < 2000) begin
            step(1, 1, far_px(m.bx));
            n++;
        end
        chk("miss_timeout", 43'(n < 2000), 43'(1));
        chk("miss_state", 43'({state, ball_y}), 43'({3'd3, 10'd510}));
        step(0, 0, 200);
        chk("reserve", 43'({state, lives, ball_x, ball_y}),
            43'({3'd1, 2'd2, 10'd200, 10'd491}));

        n = 0;
        while (m.st != 4 && n < 5000) begin
            px = (m.st == 2) ? far_px(m.bx) : 300;
            step(1, 0, px);
            n++;
        end
        chk("over_timeout", 43'(n < 5000), 43'(1));
        chk("over_flags", 43'({game_over, paddle_en, lives}),
            43'({1'b1, 1'b0, 2'd0}));
        step(1, 0, 600);
        step(1, 0, 100);
        step(0, 1, 100);
        chk("over_idle", 43'({state, lives, score}),
            43'({3'd0, 2'd3, 16'd1}));
        step(1, 1, 320);
        chk("restart", 43'({state, score}), 43'({3'd1, 16'd0}));

        for (int i = 0; i < 70; i++)
            step(1, 0, 320);
        chk("pre_rst_play", 43'(state), 43'(2));
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", obs(), pack(mreset()));
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
